emergency_request_ctrl: RTL and testbench

EMERGENCY_REQUEST_CTRL -- requirements
Module: emergency_request_ctrl

---
 rtl/emg_pkg.sv | 25 ++
 rtl/bit_sync.sv | 21 ++
 rtl/emergency_request_ctrl.sv | 121 ++++++++++++
 tb/tb_emergency_request_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/emg_pkg.sv
// Shared types and default timing for the emergency request controller.
package emg_pkg;

    localparam int unsigned CNT_W = 8;

    localparam int unsigned DEB_TICKS_DEF  = 4;
    localparam int unsigned HOLD_TICKS_DEF = 8;
    localparam int unsigned COOL_TICKS_DEF = 4;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_QUAL = 2'd1,
        ST_HOLD = 2'd2,
        ST_COOL = 2'd3
    } emg_state_e;

    // Increment that sticks at lim instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
        return (v == lim) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous level.
module bit_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/emergency_request_ctrl.sv
// Debounces an asynchronous emergency request, holds the emergency level for a
// minimum time, then enforces a cooldown window before a new request is accepted.
module emergency_request_ctrl
    import emg_pkg::*;
#(
    parameter int unsigned DEB_TICKS  = DEB_TICKS_DEF,
    parameter int unsigned HOLD_TICKS = HOLD_TICKS_DEF,
    parameter int unsigned COOL_TICKS = COOL_TICKS_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             emg_raw,
    input  logic             tick,
    input  logic             clr,
    output logic             emergency,
    output logic             cooldown,
    output logic [CNT_W-1:0] req_count
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_TICKS - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOL_TICKS - 1);

    logic s;

    emg_state_e       state_q, state_d;
    logic [CNT_W-1:0] deb_q, deb_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] cool_q, cool_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    bit_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (emg_raw),
        .q     (s)
    );

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            deb_q   <= '0;
            hold_q  <= '0;
            cool_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            deb_q   <= deb_d;
            hold_q  <= hold_d;
            cool_q  <= cool_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; clr beats qualification and hold expiry.
    always_comb begin
        state_d = state_q;
        deb_d   = deb_q;
        hold_d  = hold_q;
        cool_d  = cool_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (s) begin
                    state_d = ST_QUAL;
                    deb_d   = '0;
                end
            end

            ST_QUAL: begin
                if (clr || !s) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (deb_q == DEB_LAST) begin
                        state_d = ST_HOLD;
                        hold_d  = '0;
                        cnt_d   = sat_inc(cnt_q, CNT_MAX);
                    end else begin
                        deb_d = deb_q + CNT_W'(1);
                    end
                end
            end

            ST_HOLD: begin
                if (clr) begin
                    state_d = ST_COOL;
                    cool_d  = '0;
                end else if (tick) begin
                    if (hold_q == HOLD_LAST && !s) begin
                        state_d = ST_COOL;
                        cool_d  = '0;
                    end else begin
                        hold_d = sat_inc(hold_q, HOLD_LAST);
                    end
                end
            end

            ST_COOL: begin
                if (tick) begin
                    if (cool_q == COOL_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        cool_d = cool_q + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs depend on registered state only.
    assign emergency = (state_q == ST_HOLD);
    assign cooldown  = (state_q == ST_COOL);
    assign req_count = cnt_q;

endmodule

// File: tb/tb_emergency_request_ctrl.sv
// Self-checking bench for emergency_request_ctrl: vector table, directed corner
// sequences and randomized traffic against a tick-counting reference model.
module tb_emergency_request_ctrl;

    localparam int unsigned DEB  = 4;
    localparam int unsigned HOLD = 8;
    localparam int unsigned COOL = 4;

    localparam int M_IDLE = 0;
    localparam int M_QUAL = 1;
    localparam int M_HOLD = 2;
    localparam int M_COOL = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       emg_raw = 1'b0;
    logic       tick = 1'b0;
    logic       clr = 1'b0;
    logic       emergency;
    logic       cooldown;
    logic [7:0] req_count;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: pipeline of raw samples plus ticks remaining/elapsed.
    bit m_p0, m_p1;
    int m_mode, m_need, m_hold, m_cool, m_cnt;

    typedef struct {
        bit raw;
        bit tk;
        bit cl;
        bit e;
        bit c;
        int cnt;
    } vec_t;

    vec_t tbl[30];

    always #5 clk = ~clk;

    emergency_request_ctrl #(
        .DEB_TICKS  (DEB),
        .HOLD_TICKS (HOLD),
        .COOL_TICKS (COOL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .emg_raw   (emg_raw),
        .tick      (tick),
        .clr       (clr),
        .emergency (emergency),
        .cooldown  (cooldown),
        .req_count (req_count)
    );

    function automatic void model_step(input bit raw, input bit tk, input bit cl, input bit rst);
        bit s;
        s = m_p1;
        if (!rst) begin
            m_p0 = 1'b0; m_p1 = 1'b0;
            m_mode = M_IDLE; m_need = 0; m_hold = 0; m_cool = 0; m_cnt = 0;
            return;
        end
        m_p1 = m_p0;
        m_p0 = raw;
        case (m_mode)
            M_IDLE: if (s) begin m_mode = M_QUAL; m_need = DEB; end
            M_QUAL: begin
                if (cl || !s) m_mode = M_IDLE;
                else if (tk) begin
                    m_need = m_need - 1;
                    if (m_need == 0) begin
                        m_mode = M_HOLD;
                        m_hold = 0;
                        if (m_cnt < 255) m_cnt = m_cnt + 1;
                    end
                end
            end
            M_HOLD: begin
                if (cl) begin m_mode = M_COOL; m_cool = 0; end
                else if (tk) begin
                    if (!s && m_hold >= int'(HOLD) - 1) begin m_mode = M_COOL; m_cool = 0; end
                    else m_hold = m_hold + 1;
                end
            end
            default: begin
                if (tk) begin
                    m_cool = m_cool + 1;
                    if (m_cool == int'(COOL)) m_mode = M_IDLE;
                end
            end
        endcase
    endfunction

    task automatic step(input bit raw, input bit tk, input bit cl, input bit rst);
        @(negedge clk);
        emg_raw = raw; tick = tk; clr = cl; reset = rst;
        @(posedge clk);
        model_step(raw, tk, cl, rst);
        #1;
    endtask

    task automatic check(input string name, input bit e, input bit c, input int cnt);
        n_vec++;
        if (emergency !== e || cooldown !== c || req_count !== 8'(cnt)) begin
            n_err++;
            $display("FAIL %s: got emergency=%0b cooldown=%0b req_count=%0d, want %0b %0b %0d",
                     name, emergency, cooldown, req_count, e, c, cnt);
        end
    endtask

    task automatic check_model(input string name);
        check(name, bit'(m_mode == M_HOLD), bit'(m_mode == M_COOL), m_cnt);
    endtask

    task automatic cmp_int(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    initial begin
        int ecnt, ccnt;
        bit raw;

        // Clean request, a cooldown-time clr, an idle clr, then a 3-cycle glitch.
        for (int k = 0; k < 30; k++) begin
            tbl[k].raw = (k <= 4) || (k >= 20 && k <= 22);
            tbl[k].tk  = 1'b1;
            tbl[k].cl  = (k == 15) || (k == 19);
            tbl[k].e   = (k >= 6 && k <= 13);
            tbl[k].c   = (k >= 14 && k <= 17);
            tbl[k].cnt = (k >= 6) ? 1 : 0;
        end

        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        check("reset", 0, 0, 0);

        for (int k = 0; k < 30; k++) begin
            step(tbl[k].raw, tbl[k].tk, tbl[k].cl, 1);
            check($sformatf("tbl%0d", k), tbl[k].e, tbl[k].c, tbl[k].cnt);
        end

        // Long request: emergency persists while s stays high.
        ecnt = 0; ccnt = 0;
        for (int k = 0; k < 50; k++) begin
            step(k < 30, 1, 0, 1);
            check_model($sformatf("long%0d", k));
            ecnt += int'(emergency);
            ccnt += int'(cooldown);
        end
        cmp_int("long_hold_cycles", ecnt, 26);
        cmp_int("long_cool_cycles", ccnt, 4);
        cmp_int("long_count", int'(req_count), 2);

        // clr during the third HOLD cycle.
        for (int k = 0; k < 16; k++) begin
            step(k <= 4, 1, k == 9, 1);
            if (k == 8)  check("clr_hold_pre", 1, 0, 3);
            if (k == 9)  check("clr_hold_cut", 0, 1, 3);
            if (k == 12) check("clr_hold_cool", 0, 1, 3);
            if (k == 13) check("clr_hold_idle", 0, 0, 3);
            check_model($sformatf("clrh%0d", k));
        end

        // clr coincident with qualification.
        for (int k = 0; k < 12; k++) begin
            step(k <= 4, 1, k == 6, 1);
            if (k == 6) check("clr_qual", 0, 0, 3);
            if (k == 7) check("clr_qual_after", 0, 0, 3);
            check_model($sformatf("clrq%0d", k));
        end

        // Reset for one edge in the middle of HOLD.
        for (int k = 0; k < 14; k++) begin
            step(k <= 4, 1, 0, k != 8);
            if (k == 7) check("rst_hold_pre", 1, 0, 4);
            if (k == 8) check("rst_hold", 0, 0, 0);
            if (k == 9) check("rst_hold_after", 0, 0, 0);
            check_model($sformatf("rsth%0d", k));
        end

        // Sparse tick: every 4th cycle.
        ecnt = 0; ccnt = 0;
        for (int k = 0; k < 80; k++) begin
            step(k <= 23, (k % 4) == 0, 0, 1);
            check_model($sformatf("sparse%0d", k));
            ecnt += int'(emergency);
            ccnt += int'(cooldown);
        end
        cmp_int("sparse_hold_cycles", ecnt, 32);
        cmp_int("sparse_cool_cycles", ccnt, 16);
        cmp_int("sparse_count", int'(req_count), 1);

        // Dropout spanning two ticks during qualification.
        ecnt = 0;
        for (int k = 0; k < 40; k++) begin
            step(k <= 9, (k % 4) == 0, 0, 1);
            check_model($sformatf("drop%0d", k));
            ecnt += int'(emergency);
        end
        cmp_int("drop_hold_cycles", ecnt, 0);
        cmp_int("drop_count", int'(req_count), 1);

        // 256 accepted requests saturate the counter.
        step(0, 1, 0, 0);
        for (int r = 0; r < 256; r++) begin
            for (int k = 0; k < 13; k++) begin
                step(k <= 4, 1, k == 7, 1);
                check_model($sformatf("sat%0d_%0d", r, k));
            end
            if (r == 0)   cmp_int("sat_first", int'(req_count), 1);
            if (r == 254) cmp_int("sat_255", int'(req_count), 255);
        end
        cmp_int("sat_256", int'(req_count), 255);

        // Randomized traffic against the model.
        step(0, 1, 0, 0);
        raw = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 5) == 0) raw = ~raw;
            step(raw, $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 299) != 0);
            check_model($sformatf("rand%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
